// File: rtl/tx_eth_pkg.sv
// Shared types and constants for the transmit-side ethernet driver.
package tx_eth_pkg;

  localparam int QW_W        = 64;
  localparam int KEEP_W      = 8;
  localparam int LEN_W       = 13;
  localparam int OFIFO_DEPTH = 4;
  localparam int OFIFO_W     = QW_W + KEEP_W + 1;  // {tlast, tkeep, tdata}
  localparam int RSK_LEAD    = 16;                 // synchroniser lead that qualifies rsk

  // One-hot driver states.
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_STRM  = 6'b000010,
    ST_DRAIN = 6'b000100,
    ST_SYNC  = 6'b001000,
    ST_ARB   = 6'b010000,
    ST_LATCH = 6'b100000
  } tx_state_e;

endpackage

// File: rtl/tx_eth_ofifo.sv
// Four-entry output FIFO between the ibuf read pipeline and the MAC.
// The head is masked to zero while empty so the MAC bus idles at 0.
module tx_eth_ofifo
  import tx_eth_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [OFIFO_W-1:0] push_data,
  input  logic               pop,
  output logic [OFIFO_W-1:0] head_data,
  output logic               head_vld,
  output logic [2:0]         free
);

  logic [OFIFO_W-1:0] mem [OFIFO_DEPTH];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [2:0]         count;
  logic               do_push;
  logic               do_pop;

  assign free      = 3'(OFIFO_DEPTH) - count;
  assign head_vld  = (count != 3'd0);
  assign do_pop    = pop & head_vld;
  assign do_push   = push & (free != 3'd0);
  assign head_data = head_vld ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

  // Storage array; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tx_eth_drv.sv
// Streams framed packets from the ibuf to the 10G MAC, owns the ibuf read
// pointer, returns consumed space and hands the synchroniser each header.
module tx_eth_drv
  import tx_eth_pkg::*;
#(
  parameter int BW = 9
)(
  input  logic              clk,
  input  logic              rst,
  output logic [BW-1:0]     rd_addr,
  input  logic [QW_W-1:0]   rd_data,
  input  logic [BW:0]       committed_prod,
  output logic [BW:0]       committed_cons,
  input  logic              trig,
  input  logic [LEN_W-1:0]  qw_len,
  input  logic [KEEP_W-1:0] lst_ben,
  input  logic              rsk,
  output logic              rsk_tk,
  output logic              sync,
  input  logic              rsk_en,
  output logic [QW_W-1:0]   m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  localparam int PW = BW + 1;

  tx_state_e          state;
  tx_state_e          state_nxt;
  logic [PW-1:0]      rd_ptr;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [KEEP_W-1:0]  ben_q;
  logic               rsk_d;
  logic               rd_vld_p0;
  logic               rd_lst_p0;
  logic               start;
  logic               issue;
  logic               issue_lst;
  logic               fin;
  logic               prod_ok;
  logic [2:0]         fifo_free;
  logic               fifo_vld;
  logic [OFIFO_W-1:0] fifo_head;
  logic [OFIFO_W-1:0] push_data;

  assign rd_addr   = rd_ptr[BW-1:0];
  // The QW at the read pointer exists only once the producer has moved past it.
  assign prod_ok   = (rd_ptr != committed_prod);
  assign issue_lst = (cnt == len_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    issue     = 1'b0;
    fin       = 1'b0;
    sync      = 1'b0;
    rsk_tk    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          start     = 1'b1;
          state_nxt = ST_STRM;
        end
      end
      ST_STRM: begin
        if (len_q == '0) begin
          state_nxt = ST_DRAIN;
        end else if ((fifo_free > {2'b00, rd_vld_p0}) && prod_ok) begin
          // Only read when the FIFO can absorb this QW plus any in flight.
          issue = 1'b1;
          if (issue_lst) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last read returns during this cycle and is pushed at its end,
        // so the consumed space can be released on the same edge.
        fin       = 1'b1;
        state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        sync      = 1'b1;
        state_nxt = ST_ARB;
      end
      ST_ARB: begin
        rsk_tk    = rsk & rsk_en;
        state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        if (trig || rsk_d) begin
          start     = 1'b1;
          state_nxt = ST_STRM;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read pointer, frame length, consumer pointer and read-issue stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr         <= '0;
      committed_cons <= '0;
      len_q          <= '0;
      cnt            <= '0;
      rd_vld_p0      <= 1'b0;
      rd_lst_p0      <= 1'b0;
      rsk_d          <= 1'b0;
    end else begin
      rsk_d     <= rsk_tk;
      rd_vld_p0 <= issue;
      rd_lst_p0 <= issue & issue_lst;
      if (start) begin
        rd_ptr <= rd_ptr + PW'(1);          // skip the header
        len_q  <= qw_len;
        cnt    <= LEN_W'(1);
      end else if (issue) begin
        rd_ptr <= rd_ptr + PW'(1);
        cnt    <= cnt + LEN_W'(1);
      end
      if (fin) committed_cons <= committed_cons + PW'(len_q) + PW'(1);
    end
  end

  // Last-QW byte enables travel with the frame, not with reset.
  always_ff @(posedge clk) begin
    if (start) ben_q <= lst_ben;
  end

  // ---- stage p0 -> FIFO: ibuf data lands one cycle after its address ----
  assign push_data = {rd_lst_p0, (rd_lst_p0 ? ben_q : {KEEP_W{1'b1}}), rd_data};

  tx_eth_ofifo u_ofifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_vld_p0),
    .push_data (push_data),
    .pop       (m_axis_tready),
    .head_data (fifo_head),
    .head_vld  (fifo_vld),
    .free      (fifo_free)
  );

  assign m_axis_tvalid = fifo_vld;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_head;

endmodule

// File: tb/tb_tx_eth_drv.sv
// Directed bench for tx_eth_drv with a 16-QW ibuf model.
module tb_tx_eth_drv;

  localparam int BW = 4;

  logic          clk;
  logic          rst;
  logic [BW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic [BW:0]   committed_prod;
  logic [BW:0]   committed_cons;
  logic          trig;
  logic [12:0]   qw_len;
  logic [7:0]    lst_ben;
  logic          rsk;
  logic          rsk_tk;
  logic          sync;
  logic          rsk_en;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;

  tx_eth_drv #(.BW(BW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .committed_prod (committed_prod),
    .committed_cons (committed_cons),
    .trig           (trig),
    .qw_len         (qw_len),
    .lst_ben        (lst_ben),
    .rsk            (rsk),
    .rsk_tk         (rsk_tk),
    .sync           (sync),
    .rsk_en         (rsk_en),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [3:0] a);
    logic [31:0] w;
    w = 32'hDA7A_0000 | {28'h0, a};
    return {w, ~w};
  endfunction

  // ibuf: synchronous read, data one cycle after the address
  logic [63:0] ibuf [16];
  always @(posedge clk) rd_data <= ibuf[rd_addr];

  // MAC-side monitor
  logic [72:0] beats [$];
  int          gaps     = 0;
  int          tk_cnt   = 0;
  int          sync_cnt = 0;
  logic [3:0]  sync_addr = '0;
  bit          mid_frame = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      mid_frame <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        beats.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        mid_frame <= !m_axis_tlast;
      end else if (mid_frame && !m_axis_tvalid) begin
        gaps <= gaps + 1;
      end
      if (rsk_tk) tk_cnt <= tk_cnt + 1;
      if (sync) begin
        sync_cnt  <= sync_cnt + 1;
        sync_addr <= rd_addr;
      end
    end
  end

  // tready driver: steady high or toggling
  bit tog = 1'b0;
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = tog ? ~m_axis_tready : 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_sync(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sync) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {127'b0, ok}, 128'd1);
  endtask

  typedef struct {
    logic [12:0] qw_len;
    logic [7:0]  lst_ben;
    logic [4:0]  prod;
    bit          tog;
    logic [3:0]  exp_first;
    logic [4:0]  exp_cons;
    logic [3:0]  exp_hdr;
  } frame_t;

  // Check every expected beat of a frame starting at beat index b0.
  task automatic chk_beats(input string name, input int b0, input logic [12:0] len,
                           input logic [7:0] ben, input logic [3:0] first);
    logic [72:0] act;
    logic [72:0] exp;
    logic [3:0]  a;
    logic        lst;
    chk({name, "_count"}, 128'(beats.size() - b0), 128'(len));
    for (int i = 0; i < int'(len); i++) begin
      a   = first + 4'(i);
      lst = (i == int'(len) - 1);
      exp = {lst, (lst ? ben : 8'hFF), pat(a)};
      act = (b0 + i < beats.size()) ? beats[b0 + i] : '0;
      chk($sformatf("%s_beat%0d", name, i), 128'(act), 128'(exp));
    end
  endtask

  task automatic run_frame(input string name, input frame_t f);
    int b0;
    int g0;
    int s0;
    b0 = beats.size();
    g0 = gaps;
    s0 = sync_cnt;
    committed_prod = f.prod;
    qw_len  = f.qw_len;
    lst_ben = f.lst_ben;
    tog     = f.tog;
    trig    = 1'b1;
    @(posedge clk); #1;
    trig    = 1'b0;
    wait_sync({name, "_sync_seen"});
    repeat (30) @(posedge clk);
    #1;
    tog = 1'b0;
    chk_beats(name, b0, f.qw_len, f.lst_ben, f.exp_first);
    chk({name, "_gaps"}, 128'(gaps - g0), 128'd0);
    chk({name, "_sync_pulses"}, 128'(sync_cnt - s0), 128'd1);
    chk({name, "_sync_addr"}, 128'(sync_addr), 128'(f.exp_hdr));
    chk({name, "_cons"}, 128'(committed_cons), 128'(f.exp_cons));
  endtask

  frame_t tbl [4];
  frame_t post;

  initial begin
    int b0;
    int g0;
    int t0;
    bit ok;

    for (int i = 0; i < 16; i++) ibuf[i] = pat(4'(i));
    rst = 1'b0;
    trig = 1'b0;
    qw_len = '0;
    lst_ben = '0;
    rsk = 1'b0;
    rsk_en = 1'b0;
    committed_prod = '0;

    // qw_len, lst_ben, prod, tog, first payload, cons after, next header
    tbl[0] = '{13'd3, 8'h0F, 5'd4,  1'b0, 4'd1,  5'd4,  4'd4};   // single frame
    tbl[1] = '{13'd8, 8'hFF, 5'd13, 1'b1, 4'd5,  5'd13, 4'd13};  // back-pressure
    tbl[2] = '{13'd0, 8'h00, 5'd14, 1'b0, 4'd0,  5'd14, 4'd14};  // header only
    tbl[3] = '{13'd4, 8'h03, 5'd19, 1'b0, 4'd15, 5'd19, 4'd3};   // wraps, wrap bit flips

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("rst_tdata",  128'(m_axis_tdata),  128'd0);
    chk("rst_tkeep",  128'(m_axis_tkeep),  128'd0);
    chk("rst_tlast",  128'(m_axis_tlast),  128'd0);
    chk("rst_rd_addr", 128'(rd_addr), 128'd0);
    chk("rst_cons",   128'(committed_cons), 128'd0);
    chk("rst_sync",   128'(sync), 128'd0);
    chk("rst_rsk_tk", 128'(rsk_tk), 128'd0);
    rst = 1'b1;

    // boot: speculation offered but nothing may start without trig
    rsk = 1'b1;
    rsk_en = 1'b1;
    committed_prod = 5'd4;
    repeat (12) @(posedge clk);
    #1;
    chk("boot_beats", 128'(beats.size()), 128'd0);
    chk("boot_sync",  128'(sync_cnt), 128'd0);
    chk("boot_rsk_tk", 128'(tk_cnt), 128'd0);
    rsk_en = 1'b0;

    for (int i = 0; i < 4; i++) run_frame($sformatf("frm%0d", i), tbl[i]);
    chk("no_spec_when_disabled", 128'(tk_cnt), 128'd0);

    // speculative send: header-only frame at 3, then rsk taken for header 4
    committed_prod = 5'd22;
    rsk_en = 1'b1;
    rsk    = 1'b1;
    qw_len = 13'd0;
    lst_ben = 8'h00;
    b0 = beats.size();
    g0 = gaps;
    t0 = tk_cnt;
    trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
    qw_len = 13'd5;
    lst_ben = 8'h3F;
    wait_sync("spec_hdr_sync_seen");
    chk("spec_hdr_sync_addr", 128'(rd_addr), 128'd4);
    @(negedge clk);
    chk("spec_rsk_tk_in_arb", 128'(rsk_tk), 128'd1);
    @(posedge clk); #1;
    rsk = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("spec_stall_beats",  128'(beats.size() - b0), 128'd1);
    chk("spec_stall_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("spec_stall_cons",   128'(committed_cons), 128'd20);
    committed_prod = 5'd26;
    wait_sync("spec_sync_seen");
    repeat (20) @(posedge clk);
    #1;
    chk_beats("spec", b0, 13'd5, 8'h3F, 4'd5);
    chk("spec_gap_seen", 128'(gaps - g0 > 0), 128'd1);
    chk("spec_rsk_tk_pulses", 128'(tk_cnt - t0), 128'd1);
    chk("spec_cons", 128'(committed_cons), 128'd26);
    chk("spec_next_hdr", 128'(sync_addr), 128'd10);

    // async reset during beat 2 of a frame at header 10
    committed_prod = 5'd1;
    qw_len = 13'd6;
    lst_ben = 8'hFF;
    b0 = beats.size();
    trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (beats.size() >= b0 + 1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rstmid_beat1_seen", 128'(ok), 128'd1);
    #2;
    chk("rstmid_tvalid_before", 128'(m_axis_tvalid), 128'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("rstmid_tdata",  128'(m_axis_tdata),  128'd0);
    chk("rstmid_tlast",  128'(m_axis_tlast),  128'd0);
    chk("rstmid_rd_addr", 128'(rd_addr), 128'd0);
    chk("rstmid_cons",   128'(committed_cons), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    post = '{13'd2, 8'h01, 5'd3, 1'b0, 4'd1, 5'd3, 4'd3};
    run_frame("post_rst", post);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
